// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of an 8N1 UART transmitter.
//
// Bytes pushed on tx_valid/tx_ready are queued. Each byte is popped into a
// shift register and sent LSB first. A frame is one start bit, eight data
// bits and one stop bit. The bit period is selected per frame by b_sel,
// which is latched at the pop that starts the frame. A pop on the last
// stop-bit cycle gives back-to-back frames with no idle gap.
//
// Ports:
//   clk        system clock (50 MHz), rising edge
//   rst        asynchronous active-high reset
//   b_sel      baud select: 00=4800 01=9600 10=57600 11=115200
//   tx_data    byte to queue
//   tx_valid   tx_data is valid this cycle
//   tx_ready   FIFO can accept a byte (fifo_count < FIFO_DEPTH)
//   tx         registered serial line, idle high
//   busy       frame in progress or bytes queued
//   fifo_count bytes queued, excluding the byte in the shifter
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  b_sel,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [13:0]   div_m1;
    logic [13:0]   sel_m1;
    logic [13:0]   baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shifter;
    logic          push;
    logic          pop;
    logic          bit_end;

    // Bit period minus one, so the baud counter runs 0..divisor-1.
    always_comb begin
        sel_m1 = 14'd433;
        case (b_sel)
            2'b00:   sel_m1 = 14'd10416;
            2'b01:   sel_m1 = 14'd5207;
            2'b10:   sel_m1 = 14'd867;
            default: sel_m1 = 14'd433;
        endcase
    end

    assign bit_end  = (baud_cnt == div_m1);
    assign tx_ready = (fifo_count < FULL);
    assign push     = tx_valid && tx_ready;
    // Popping on the final stop-bit cycle starts the next frame directly.
    assign pop      = ((state == IDLE) || ((state == STOP) && bit_end))
                      && (fifo_count != '0);
    assign busy     = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
            div_m1   <= '0;
        end else if (pop) begin
            shifter  <= mem[rd_ptr];
            div_m1   <= sel_m1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            state    <= START;
            tx       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx       <= shifter[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            // Next bit is shifter[1]; drive it as the shift happens.
                            shifter <= shifter >> 1;
                            tx      <= shifter[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench for uart_tx_fifo.
//
// The reference model keeps the queue as an SV queue. It keeps the frame in
// flight as a cycle offset into a 10-bit-period frame. It derives the
// expected line level from that offset by arithmetic. All DUT outputs are
// compared after every clock edge.
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic [1:0]    b_sel    = 2'b11;
    logic [7:0]    tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [7:0]  mq[$];
    bit          m_active = 1'b0;
    int unsigned m_pos    = 0;
    int unsigned m_div    = 1;
    logic [7:0]  m_byte   = '0;

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .b_sel      (b_sel),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
            if (failures >= 40) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    endtask

    function automatic int unsigned div_of(input logic [1:0] s);
        case (s)
            2'b00:   return 10417;
            2'b01:   return 5208;
            2'b10:   return 868;
            default: return 434;
        endcase
    endfunction

    function automatic logic exp_tx();
        int unsigned b;
        if (!m_active) return 1'b1;
        b = m_pos / m_div;
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    task automatic check_outputs();
        check("tx", 32'(tx), 32'(exp_tx()));
        check("count", 32'(fifo_count), 32'(mq.size()));
        check("ready", 32'(tx_ready), 32'(mq.size() < DEPTH));
        check("busy", 32'(busy), 32'(m_active || (mq.size() != 0)));
    endtask

    // Advance model and DUT by one clock edge, then compare.
    task automatic step();
        int unsigned d;
        bit last;
        bit do_pop;
        bit do_push;
        if (!rst) begin
            d       = div_of(b_sel);
            last    = m_active && (m_pos == 10 * m_div - 1);
            do_pop  = (!m_active || last) && (mq.size() != 0);
            do_push = tx_valid && (mq.size() < DEPTH);
            if (do_pop) begin
                m_byte   = mq.pop_front();
                m_div    = d;
                m_pos    = 0;
                m_active = 1'b1;
            end else if (last) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_pos++;
            end
            if (do_push) mq.push_back(tx_data);
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic run_until_idle(input int limit);
        int i;
        i = 0;
        while ((m_active || mq.size() != 0) && i < limit) begin
            step();
            i++;
        end
        check("drain_bound", 32'(i < limit), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tx", 32'(tx), 32'd1);
    endtask

    // Reset asserted between edges; outputs must respond without a clock.
    task automatic async_reset(input int hold);
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        m_active = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        run(hold);
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        int tries;

        async_reset(2);

        // Back-to-back frames at 115200; first push right after reset release.
        b_sel = 2'b11;
        push_byte(8'h55);
        push_byte(8'hAA);
        run_until_idle(20000);

        // Baud change mid-frame only applies to the next popped byte.
        b_sel = 2'b10;
        push_byte(8'($urandom));
        run(1000);
        b_sel = 2'b11;
        push_byte(8'($urandom));
        run_until_idle(20000);

        // Random pushes past full: ignored while full, pointers wrap.
        acc   = 0;
        tries = 0;
        while (acc < 9 && tries < 60000) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            if (tx_valid && mq.size() < DEPTH) acc++;
            step();
            tries++;
        end
        tx_valid = 1'b0;
        check("fill_bound", 32'(acc), 32'd9);
        run_until_idle(50000);

        // Slow rates: start bit and first data bit, then reset mid-frame.
        b_sel = 2'b00;
        push_byte(8'($urandom));
        run(10417 + 40);
        async_reset(2);
        b_sel = 2'b01;
        push_byte(8'($urandom));
        run(5208 + 40);
        b_sel = 2'b11;
        run(200);
        async_reset(2);

        // Reset during data bit 3 with three bytes queued.
        b_sel = 2'b11;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        run(434 * 4 + 100);
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        async_reset(2);
        run(1000);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, meaning the number of FIFO entries; legal values are 8 or 16.
REQ-002 Port clk, input, 1 bit: system clock, 50 MHz, all logic on the rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 Port b_sel, input, 2 bits: baud select; 00=4800, 01=9600, 10=57600, 11=115200.
REQ-005 Port tx_data, input, 8 bits: byte to queue.
REQ-006 Port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-007 Port tx_ready, output, 1 bit: FIFO can accept a byte; equals (fifo_count < FIFO_DEPTH).
REQ-008 Port tx, output, 1 bit: UART serial line, registered, idle high.
REQ-009 Port busy, output, 1 bit: high when the FSM is not in IDLE or fifo_count is not 0.
REQ-010 Port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of bytes queued, excluding the byte in the shifter.

Function
REQ-011 Bit period SHALL be a fixed cycle count per b_sel: 00=10417, 01=5208, 10=868, 11=434 clk cycles.
REQ-012 Frame SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1); 10 bit periods total.
REQ-013 Push: on an edge where tx_valid and tx_ready are both high, tx_data SHALL be written at the write pointer and the pointer incremented.
REQ-014 tx_valid while tx_ready is low SHALL be ignored; the FIFO contents SHALL NOT change and the byte is not accepted.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 Pop condition: (state==IDLE, or the last cycle of STOP) and fifo_count>0; on that edge the head byte loads into the shifter, b_sel latches, the bit counter clears, and the state goes to START.
REQ-017 Pop at the last STOP cycle SHALL give back-to-back frames with zero idle cycles between the stop bit and the next start bit.
REQ-018 If the pop condition is false at the last STOP cycle, the FSM SHALL go to IDLE and tx SHALL stay 1.
REQ-019 Transitions: START->DATA after 1 bit period; DATA->STOP after 8 bit periods; STOP->IDLE or START per REQ-016/018.
REQ-020 tx SHALL be 0 in START, shifter bit[0] in DATA (shift right at each bit boundary), and 1 in STOP and IDLE.
REQ-021 Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE SHALL drive tx low from edge N+1 (pop at edge N+1, tx registered at edge N+1).
REQ-022 Simultaneous push and pop: fifo_count SHALL be unchanged and both pointers SHALL advance.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 A full FIFO SHALL drop tx_ready; an empty FIFO SHALL issue no pop.
REQ-025 b_sel changes mid-frame SHALL NOT affect the current frame; the new value applies from the next pop.
REQ-026 The baud counter SHALL count 0..divisor-1; a bit boundary occurs when the count equals divisor-1.

Reset
REQ-027 While rst is high: tx=1, state=IDLE, fifo_count=0, pointers=0, busy=0, tx_ready=1, baud and bit counters=0.
REQ-028 rst asserted mid-frame SHALL force tx=1 immediately (asynchronously) and discard the in-flight byte and all queued bytes.
REQ-029 The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-030 b_sel=01, push 0x0A into an idle block -> tx=0 for 5208 cycles, then bits 0,1,0,1,0,0,0,0 each 5208 cycles, then 1 for 5208 cycles; busy falls after 52080 cycles.
REQ-031 b_sel=11, push 0x55 then 0xAA on consecutive cycles -> two contiguous frames, 434 cycles per bit, 8680 cycles total, no idle gap between frames.
REQ-032 b_sel=00, tx_valid held high from idle with FIFO_DEPTH=8 -> exactly 9 bytes accepted (edges 0..8); tx_ready low from edge 9; tx_ready returns high on the edge of the next pop (about 104170 cycles later).
REQ-033 Start a frame at b_sel=01, switch to b_sel=11 after 1000 cycles with a second byte queued -> first frame at 5208 cycles/bit, second frame at 434 cycles/bit.
REQ-034 rst pulsed during DATA bit 3 with 3 bytes queued -> tx=1 within the same cycle; after release fifo_count=0, busy=0, tx_ready=1, and no further frames are sent.
REQ-035 Push 20 bytes 0x00..0x13 with FIFO_DEPTH=8, pacing on tx_ready -> the decoded serial stream is 0x00..0x13 in order, confirming pointer wrap.
